// File: rtl/gray_counter_ud_pkg.sv
// Shared types for the up/down Gray counter: the per-edge step decision
// taken by the next-state logic.
package gray_counter_ud_pkg;

    typedef enum logic [2:0] {
        STEP_HOLD,
        STEP_LOAD,
        STEP_INC,
        STEP_DEC,
        STEP_TOP,     // up-step attempted at binary max
        STEP_BOTTOM   // down-step attempted at binary zero
    } step_e;

endpackage

// File: rtl/gray_counter_ud_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits
// from the MSB down to that position.
module gray_counter_ud_gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign b[i] = ^g[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter_ud.sv
// Parametrised up/down Gray-code counter with Gray parallel load, wrap or
// saturate at the ends, sticky overflow/underflow flags and a wrap pulse.
module gray_counter_ud
    import gray_counter_ud_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int SATURATE = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] st;
    logic             ovf;
    logic             udf;
    logic             wp;
    logic [WIDTH-1:0] load_bin;
    step_e            step;

    gray_counter_ud_gray2bin #(.WIDTH(WIDTH)) u_load_g2b (
        .g (LoadGray),
        .b (load_bin)
    );

    always_comb begin
        step = STEP_HOLD;
        if (Load)
            step = STEP_LOAD;
        else if (En) begin
            if (Dir)
                step = (st == MAX)  ? STEP_TOP    : STEP_INC;
            else
                step = (st == ZERO) ? STEP_BOTTOM : STEP_DEC;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            st  <= ZERO;
            ovf <= 1'b0;
            udf <= 1'b0;
            wp  <= 1'b0;
        end else begin
            wp <= 1'b0;
            // Clear first so that a same-edge overflow/underflow below wins.
            if (ClrFlag) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
            case (step)
                STEP_LOAD: st <= load_bin;
                STEP_INC:  st <= st + ONE;
                STEP_DEC:  st <= st - ONE;
                STEP_TOP: begin
                    ovf <= 1'b1;
                    if (SATURATE == 0) begin
                        st <= ZERO;
                        wp <= 1'b1;
                    end
                end
                STEP_BOTTOM: begin
                    udf <= 1'b1;
                    if (SATURATE == 0) begin
                        st <= MAX;
                        wp <= 1'b1;
                    end
                end
                default: st <= st;
            endcase
        end
    end

    assign Output    = st ^ (st >> 1);
    assign BinOut    = st;
    assign Overflow  = ovf;
    assign Underflow = udf;
    assign Wrap      = wp;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed bench: wrapping 3-bit counter and saturating 4-bit counter side by side.
module tb_gray_counter_ud;

    logic       clk = 1'b0;
    logic       rst_n;
    // 3-bit wrapping instance
    logic       a_en, a_dir, a_load, a_clr;
    logic [2:0] a_lg, a_out, a_bin;
    logic       a_ovf, a_udf, a_wrap;
    // 4-bit saturating instance
    logic       b_en, b_dir, b_load, b_clr;
    logic [3:0] b_lg, b_out, b_bin;
    logic       b_ovf, b_udf, b_wrap;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    gray_counter_ud #(.WIDTH(3), .SATURATE(0)) u_dut_a (
        .Clk(clk), .Reset_n(rst_n), .En(a_en), .Dir(a_dir), .Load(a_load),
        .LoadGray(a_lg), .ClrFlag(a_clr), .Output(a_out), .BinOut(a_bin),
        .Overflow(a_ovf), .Underflow(a_udf), .Wrap(a_wrap)
    );

    gray_counter_ud #(.WIDTH(4), .SATURATE(1)) u_dut_b (
        .Clk(clk), .Reset_n(rst_n), .En(b_en), .Dir(b_dir), .Load(b_load),
        .LoadGray(b_lg), .ClrFlag(b_clr), .Output(b_out), .BinOut(b_bin),
        .Overflow(b_ovf), .Underflow(b_udf), .Wrap(b_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] up_seq [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                               3'b101, 3'b100, 3'b000, 3'b001};

    initial begin
        logic [2:0] mbin, prev;
        int hd;
        rst_n = 1'b0;
        {a_en, a_dir, a_load, a_clr} = '0; a_lg = '0;
        {b_en, b_dir, b_load, b_clr} = '0; b_lg = '0;
        #12;
        chk("rst_out", a_out, 0);
        chk("rst_flags", {a_ovf, a_udf, a_wrap}, 0);
        rst_n = 1'b1;

        // Up-count through a full wrap
        a_en = 1'b1; a_dir = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("up_out%0d", i), a_out, up_seq[i]);
            chk($sformatf("up_ovf%0d", i), a_ovf, (i >= 7) ? 1 : 0);
            chk($sformatf("up_wrap%0d", i), a_wrap, (i == 7) ? 1 : 0);
        end

        // Down from reset wraps to max
        a_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("rst2_out", a_out, 0);
        a_en = 1'b1; a_dir = 1'b0;
        tick();
        chk("dn_out", a_out, 3'b100);
        chk("dn_bin", a_bin, 7);
        chk("dn_flags", {a_ovf, a_udf, a_wrap}, 3'b011);
        a_en = 1'b0;
        tick();
        chk("dn_hold", {a_out, a_wrap}, {3'b100, 1'b0});

        // ClrFlag coinciding with an overflow: set wins, udf clears
        a_en = 1'b1; a_dir = 1'b1; a_clr = 1'b1;
        tick();
        chk("clr_set_out", a_out, 0);
        chk("clr_set_flags", {a_ovf, a_udf, a_wrap}, 3'b101);
        a_en = 1'b0;
        tick();
        chk("clr_alone", {a_ovf, a_udf, a_wrap}, 0);
        a_clr = 1'b0;

        // Set flags, count up to 5, then asynchronous reset mid-cycle
        a_en = 1'b1; a_dir = 1'b0;
        tick();
        a_dir = 1'b1;
        tick();
        chk("pre_flags", {a_ovf, a_udf}, 2'b11);
        for (int i = 0; i < 5; i++) tick();
        chk("at5_out", a_out, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out", a_out, 0);
        chk("async_flags", {a_ovf, a_udf, a_wrap}, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("resume_bin", a_bin, 1);

        // Random walk: model, Gray consistency, single-bit steps
        mbin = a_bin;
        prev = a_out;
        for (int i = 0; i < 40; i++) begin
            a_en  = 1'($urandom_range(0, 3) != 0);
            a_dir = 1'($urandom_range(0, 1));
            tick();
            if (a_en) mbin = a_dir ? mbin + 3'd1 : mbin - 3'd1;
            chk($sformatf("rnd_bin%0d", i), a_bin, mbin);
            chk($sformatf("rnd_gray%0d", i), a_out, mbin ^ (mbin >> 1));
            hd = $countones(a_out ^ prev);
            chk($sformatf("rnd_hd%0d", i), (hd <= 1) ? 1 : 0, 1);
            prev = a_out;
        end
        a_en = 1'b0;

        // Saturating 4-bit: load max, push up three times
        b_load = 1'b1; b_lg = 4'b1000;
        tick();
        chk("b_load_bin", b_bin, 15);
        b_load = 1'b0; b_en = 1'b1; b_dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("b_sat_out%0d", i), b_out, 4'b1000);
            chk($sformatf("b_sat_fl%0d", i), {b_ovf, b_wrap}, 2'b10);
        end
        b_dir = 1'b0;
        tick();
        chk("b_dn_out", b_out, 4'b1001);
        chk("b_dn_bin", b_bin, 14);

        // Load beats En
        b_load = 1'b1; b_lg = 4'b0110; b_dir = 1'b1;
        tick();
        chk("b_ld_en_bin", b_bin, 4);
        b_load = 1'b0;
        tick();
        chk("b_next_bin", b_bin, 5);
        chk("b_next_out", b_out, 4'b0111);

        // Saturate at zero
        b_load = 1'b1; b_lg = 4'b0000;
        tick();
        b_load = 1'b0; b_dir = 1'b0;
        tick();
        chk("b_bot_out", b_out, 0);
        chk("b_bot_fl", {b_ovf, b_udf, b_wrap}, 3'b110);
        b_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/gray_counter_ud.md
Name: gray_counter_ud

Overview:
- Parametrised Gray-code counter; successor to the fixed 3-bit up-only Gray counter.
- Adds: WIDTH generalisation, up/down direction, parallel load in Gray code, wrap or saturate mode, separate sticky overflow/underflow flags with software clear, and a one-cycle wrap pulse.
- Used as a sequence/pointer generator wherever a single-bit-change count is required.

Parameters:
- WIDTH, 3, counter width in bits (≥2).
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- En  input  1  count enable.
- Dir  input  1  1 = count up, 0 = count down.
- Load  input  1  synchronous load of LoadGray.
- LoadGray  input  WIDTH  load value, Gray-encoded.
- ClrFlag  input  1  synchronous clear of Overflow and Underflow.
- Output  output  WIDTH  current count, Gray code.
- BinOut  output  WIDTH  current count, binary.
- Overflow  output  1  sticky: an up-step was attempted at binary max.
- Underflow  output  1  sticky: a down-step was attempted at binary 0.
- Wrap  output  1  one-cycle pulse on a wrap event.

Behaviour:
- State: binary register st[WIDTH-1:0], flag registers ovf and udf, and a registered wrap pulse wp.
- Output = st ^ (st >> 1), combinational from st. BinOut = st. Both change only after a Clk edge or a reset.
- Reset: Reset_n low forces st = 0, ovf = 0, udf = 0, wp = 0 immediately, without waiting for Clk. Output = 0 during reset. Reset takes effect even mid-count or mid-load.
- Priority at each rising Clk edge (Reset_n high): Load > En. With neither, st holds.
- Load: st <= gray2bin(LoadGray). The ovf/udf flags are unaffected. wp <= 0. Dir and En are ignored that cycle.
- En=1, Dir=1, st < MAX (2^WIDTH-1): st <= st+1.
- En=1, Dir=1, st == MAX:
  - SATURATE=0: st <= 0, ovf <= 1, wp <= 1.
  - SATURATE=1: st holds MAX, ovf <= 1, wp <= 0.
- En=1, Dir=0, st > 0: st <= st-1.
- En=1, Dir=0, st == 0:
  - SATURATE=0: st <= MAX, udf <= 1, wp <= 1.
  - SATURATE=1: st holds 0, udf <= 1, wp <= 0.
- wp is 0 in every cycle not listed above. Wrap = wp, so it is high for exactly one cycle after the wrapping edge.
- ClrFlag clears ovf and udf at the edge. If ClrFlag coincides with a new overflow/underflow event at the same edge, set wins and the flag stays 1.
- Flags are sticky: they are cleared only by Reset_n or ClrFlag.
- Direction may change on any cycle with no penalty. Each step moves Output by exactly one bit, wrap steps included.
- All arithmetic is modulo 2^WIDTH. No X propagation from unused bits.

Decomposition:
- Shared package: none required. Constants MAX = {WIDTH{1'b1}} and ZERO are localparams.
- One natural sub-module, gray2bin (parameter WIDTH): combinational prefix-XOR from MSB, b[i] = ^g[WIDTH-1:i].
- The sub-module is reused by the load path and by the bench checker.
- Bin-to-Gray is a one-line expression, kept inline.

Test Plan:
- WIDTH=3, SATURATE=0, Dir=1, En=1 for 9 edges from reset -> Output sequence 000,001,011,010,110,111,101,100,000,001. Overflow rises with the 000 and stays 1. Wrap is high only in the cycle Output=000 after 100.
- WIDTH=3, Dir=0 from reset, one edge -> Output=100 (bin 7), Underflow=1, Wrap=1 for one cycle, Overflow stays 0.
- WIDTH=4, SATURATE=1, Load with LoadGray=1000 (bin 15), then En=1, Dir=1 for 3 edges -> Output stays 1000, Overflow=1, Wrap never asserts. Then Dir=0, one edge -> Output=1001 (bin 14).
- WIDTH=4, Load and En both high with LoadGray=0110 (bin 4) -> BinOut=4 after the edge (no increment). Next En edge -> BinOut=5, Output=0111.
- Overflow=1, then ClrFlag=1 on the same edge as a new wrap -> Overflow remains 1. ClrFlag alone on the next edge -> Overflow=0, Underflow=0.
- Assert Reset_n=0 asynchronously between edges while the count is at 5 -> Output=0, flags=0, Wrap=0 before the next edge. Counting resumes from 0 after release.
- Random check: Output vs BinOut consistency, and single-bit Hamming distance between consecutive Output values.
